pcie_resp_tx_framer: RTL and testbench
======================================

Name: pcie_resp_tx_framer

Overview:
- Sits in the PCIe EP clock domain, on the read side of the DMA->EP response CDC FIFO (73-bit words, abits=2).
- Pops response words from the FIFO and drives the EP AXI-stream TX channel through a 2-entry skid buffer at full throughput.
- Enforces packet framing: maximum beat count, strobe sanity and packet-boundary enable gating.
- Reports packet/error statistics.

Parameters:
- max_beats, 64, maximum beats per packet (one TLP payload); range 2..256.
- cntbits, 16, width of the packet and error counters.

Ports:
- i_clk  in  1  EP clock (200 MHz)
- i_rst  in  1  asynchronous reset, active-high
- i_ena  in  1  transfer enable; sampled only at packet boundaries
- i_fifo_rdata  in  73  FIFO head word: [72]=last, [71:64]=strb, [63:0]=data
- i_fifo_empty  in  1  FIFO empty
- o_fifo_rd  out  1  pop strobe; head word is consumed on the same edge
- o_tdata  out  64  TX data
- o_tkeep  out  8  TX byte enables (the strb field)
- o_tlast  out  1  end of packet
- o_tvalid  out  1  beat valid
- i_tready  in  1  EP ready
- o_busy  out  1  FSM not in IDLE, or skid buffer not empty
- o_err_len  out  1  one-cycle pulse: max_beats reached without last
- o_err_strb  out  1  one-cycle pulse: beat with last=0 and strb!=8'hFF accepted
- o_pkt_cnt  out  cntbits  packets emitted (tlast handshakes), wraps
- o_err_cnt  out  cntbits  length plus strobe errors, wraps

Behaviour:
- FIFO is first-word-fall-through: i_fifo_rdata is valid whenever i_fifo_empty=0. o_fifo_rd is combinational: !i_fifo_empty & pop_allowed & skid_has_space.
- Reset values:
  - outputs: o_tvalid=0, o_tlast=0, o_tdata=0, o_tkeep=0, o_fifo_rd=0, all error pulses 0, counters 0, o_busy=0.
  - internal: FSM=IDLE, beat counter=0, skid buffer empty.
- Skid buffer: 2 entries, all outputs registered.
  - Space exists when fewer than 2 entries are held, or 1 entry is held and it drains this cycle.
  - Latency from pop to o_tvalid is 1 cycle. Sustained rate is 1 beat/cycle with i_tready=1.
  - o_tdata, o_tkeep and o_tlast stay stable while o_tvalid=1 and i_tready=0.
- FSM states:
  - IDLE: pop_allowed = i_ena. A pop with last=0 -> XFER with beat counter=1. A pop with last=1 forms a single-beat packet and stays in IDLE.
  - XFER: pop_allowed=1, because i_ena is ignored mid-packet.
    - Each pop increments the beat counter.
    - A pop with last=1 -> IDLE, counter=0.
    - A pop with last=0 when counter==max_beats-1 is forwarded with tlast forced to 1, o_err_len pulses, FSM -> DROP.
  - DROP: pop_allowed=1. Popped words are discarded and not written to the skid buffer. A pop with last=1 -> IDLE. No further o_err_len pulses.
- o_err_strb: evaluated on every forwarded beat whose original last bit is 0. The beat is still forwarded unmodified.
- o_err_cnt: +1 per o_err_len or o_err_strb pulse; +2 if both pulse in the same cycle.
- o_pkt_cnt: +1 on each o_tvalid & i_tready & o_tlast. Wraps at 2^cntbits.
- Simultaneous events:
  - A pop and a drain in the same cycle with 1 entry held: that entry leaves, the new word takes its place, occupancy stays 1.
  - i_ena falling mid-packet: the packet completes. i_ena=0 in IDLE: no pop, output drains normally.
- Reset asserted mid-packet: everything returns to reset values asynchronously.
  - No partial packet is flushed; the downstream EP must also be reset.
  - FIFO words are untouched; after reset the FSM restarts in IDLE, so the residual tail of the interrupted packet is sent as a new packet. This is intended.

Decomposition:
- Package pcie_dma_pkg holds:
  - constants PCIE_RESP_WIDTH=73, RESP_LAST_BIT=72, RESP_STRB_MSB=71, RESP_STRB_LSB=64, RESP_DATA_MSB=63;
  - typedef pcie_resp_word_t (packed struct: last, strb, data);
  - FSM enum {IDLE, XFER, DROP}.
- One sub-module, pcie_tx_skid: a generic 2-entry valid/ready skid buffer parameterised by data width (73 here).

Test Plan:
- Single packet of 4 beats, data 0x1..0x4, strb FF, last on beat 4, i_tready=1 -> 4 consecutive tvalid cycles, tlast on 4th, o_pkt_cnt=1, no errors.
- i_tready toggles 1,0,0,1 during an 8-beat packet -> no beat lost or duplicated, data stable during stalls, at most 2 words popped ahead of the EP.
- max_beats=4, 6-beat packet -> beats 1-4 forwarded with tlast on beat 4, o_err_len pulses once, beats 5-6 popped and dropped, o_err_cnt=1, next packet is intact.
- Beat 2 of 3 has strb=8'h0F with last=0 -> o_err_strb pulses once, beat forwarded with tkeep=0F, o_err_cnt=1.
- i_ena dropped after beat 2 of a 5-beat packet, 2 packets queued -> first packet completes, second is not popped until i_ena=1.
- i_rst asserted during beat 3 with i_tready=0 -> o_tvalid=0 immediately and counters=0; after release the remaining FIFO words are emitted as a new packet.

Source files
------------

// File: rtl/pcie_dma_pkg.sv
// Shared definitions for the DMA->EP response path.
// Response word layout (73 bits): [72]=last, [71:64]=strb, [63:0]=data.
package pcie_dma_pkg;

  localparam int unsigned PCIE_RESP_WIDTH = 73;
  localparam int unsigned RESP_LAST_BIT   = 72;
  localparam int unsigned RESP_STRB_MSB   = 71;
  localparam int unsigned RESP_STRB_LSB   = 64;
  localparam int unsigned RESP_DATA_MSB   = 63;

  typedef struct packed {
    logic                                 last;
    logic [RESP_STRB_MSB-RESP_STRB_LSB:0] strb;
    logic [RESP_DATA_MSB:0]               data;
  } pcie_resp_word_t;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DROP
  } tx_state_e;

endpackage

// File: rtl/pcie_resp_tx_framer_if.sv
// AXI-stream TX channel between the response framer and the PCIe EP.
// Signals: tdata (64), tkeep (8), tlast, tvalid driven by the master;
// tready driven by the slave.
interface pcie_resp_tx_framer_if;
  import pcie_dma_pkg::*;

  logic [RESP_DATA_MSB:0]               tdata;
  logic [RESP_STRB_MSB-RESP_STRB_LSB:0] tkeep;
  logic                                 tlast;
  logic                                 tvalid;
  logic                                 tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/pcie_tx_skid.sv
// Generic 2-entry valid/ready skid buffer with fully registered outputs.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_data/in_valid       write side; in_ready is high when fewer than
//                          2 entries are held
//   out_data/out_valid     read side, registered; held stable while stalled
//   out_ready              downstream ready
module pcie_tx_skid #(
  parameter int unsigned WIDTH = 73
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] side_q;
  logic             main_v;
  logic             side_v;
  logic             push;

  // side_v can only be set while main_v is set, so side_v alone means full
  assign in_ready  = !side_v;
  assign push      = in_valid & !side_v;
  assign out_data  = main_q;
  assign out_valid = main_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      side_q <= '0;
      main_v <= 1'b0;
      side_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      // Output register is free this cycle: refill from side first to keep order
      if (side_v) begin
        main_q <= side_q;
        main_v <= 1'b1;
        side_v <= 1'b0;
      end else begin
        main_v <= push;
        if (push) main_q <= in_data;
      end
    end else if (push) begin
      side_q <= in_data;
      side_v <= 1'b1;
    end
  end

endmodule

// File: rtl/pcie_resp_tx_framer.sv
// Pops response words from a first-word-fall-through CDC FIFO and frames
// them onto the EP AXI-stream TX channel through a 2-entry skid buffer.
// Enforces a maximum packet length (excess beats dropped after a forced
// tlast), flags non-full strobes on non-last beats, and counts packets
// and errors.
// Ports:
//   i_clk, i_rst      EP clock, asynchronous active-high reset
//   i_ena             transfer enable, honoured only between packets
//   i_fifo_rdata      FIFO head word {last, strb, data}
//   i_fifo_empty      FIFO empty
//   o_fifo_rd         pop strobe (combinational), head consumed on the edge
//   tx                AXI-stream TX master (tdata/tkeep/tlast/tvalid/tready)
//   o_busy            packet in progress or skid buffer holding data
//   o_err_len         pulse: packet reached max_beats without last
//   o_err_strb        pulse: non-last beat with strb != 8'hFF forwarded
//   o_pkt_cnt         tlast handshakes, wrapping
//   o_err_cnt         length plus strobe errors, wrapping
module pcie_resp_tx_framer
  import pcie_dma_pkg::*;
#(
  parameter int unsigned max_beats = 64,
  parameter int unsigned cntbits   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ena,
  input  logic [PCIE_RESP_WIDTH-1:0] i_fifo_rdata,
  input  logic                       i_fifo_empty,
  output logic                       o_fifo_rd,
  pcie_resp_tx_framer_if.master      tx,
  output logic                       o_busy,
  output logic                       o_err_len,
  output logic                       o_err_strb,
  output logic [cntbits-1:0]         o_pkt_cnt,
  output logic [cntbits-1:0]         o_err_cnt
);

  localparam int unsigned BW = $clog2(max_beats);
  localparam logic [BW-1:0] LAST_IDX = BW'(max_beats - 1);

  tx_state_e       state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  pcie_resp_word_t head;
  pcie_resp_word_t skid_in;
  pcie_resp_word_t skid_out;
  logic            skid_ready;
  logic            skid_valid;
  logic            pop_allowed;
  logic            pop;
  logic            fwd;
  logic            force_last;
  logic            len_hit;
  logic            strb_bad;
  logic            err_len_q;
  logic            err_strb_q;
  logic [cntbits-1:0] pkt_cnt_q;
  logic [cntbits-1:0] err_cnt_q;

  assign head = pcie_resp_word_t'(i_fifo_rdata);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    fwd         = 1'b0;
    force_last  = 1'b0;
    len_hit     = 1'b0;
    pop_allowed = (state_q == IDLE) ? i_ena : 1'b1;
    // Reset gating keeps the pop strobe low while the buffer is being cleared
    pop         = !i_rst & !i_fifo_empty & pop_allowed & skid_ready;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          fwd = 1'b1;
          if (!head.last) begin
            state_d = XFER;
            beat_d  = BW'(1);
          end
        end
      end
      XFER: begin
        if (pop) begin
          fwd = 1'b1;
          if (head.last) begin
            state_d = IDLE;
            beat_d  = '0;
          end else if (beat_q == LAST_IDX) begin
            force_last = 1'b1;
            len_hit    = 1'b1;
            state_d    = DROP;
            beat_d     = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      DROP: begin
        if (pop && head.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign strb_bad = fwd & !head.last & (head.strb != '1);

  always_comb begin
    skid_in      = head;
    skid_in.last = head.last | force_last;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      err_len_q  <= 1'b0;
      err_strb_q <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      err_len_q  <= len_hit;
      err_strb_q <= strb_bad;
      if (skid_valid && tx.tready && skid_out.last) pkt_cnt_q <= pkt_cnt_q + cntbits'(1);
      err_cnt_q  <= err_cnt_q + cntbits'(len_hit) + cntbits'(strb_bad);
    end
  end

  pcie_tx_skid #(
    .WIDTH(PCIE_RESP_WIDTH)
  ) u_skid (
    .clk       (i_clk),
    .rst       (i_rst),
    .in_data   (skid_in),
    .in_valid  (fwd),
    .in_ready  (skid_ready),
    .out_data  (skid_out),
    .out_valid (skid_valid),
    .out_ready (tx.tready)
  );

  assign o_fifo_rd  = pop;
  assign tx.tdata   = skid_out.data;
  assign tx.tkeep   = skid_out.strb;
  assign tx.tlast   = skid_out.last;
  assign tx.tvalid  = skid_valid;
  assign o_busy     = (state_q != IDLE) | skid_valid;
  assign o_err_len  = err_len_q;
  assign o_err_strb = err_strb_q;
  assign o_pkt_cnt  = pkt_cnt_q;
  assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_pcie_resp_tx_framer.sv
// Directed bench for pcie_resp_tx_framer with a FWFT FIFO model and a
// scoreboard of expected TX beats built as packets are queued.
module tb_pcie_resp_tx_framer;
  import pcie_dma_pkg::*;

  localparam int MAXB = 8;
  localparam int CNTB = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ena = 1'b0;
  logic [72:0]     fifo_rdata = '0;
  logic            fifo_empty = 1'b1;
  logic            fifo_rd;
  logic            busy;
  logic            err_len;
  logic            err_strb;
  logic [CNTB-1:0] pkt_cnt;
  logic [CNTB-1:0] err_cnt;

  pcie_resp_tx_framer_if tx ();

  pcie_resp_tx_framer #(
    .max_beats(MAXB),
    .cntbits  (CNTB)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ena        (ena),
    .i_fifo_rdata (fifo_rdata),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd    (fifo_rd),
    .tx           (tx),
    .o_busy       (busy),
    .o_err_len    (err_len),
    .o_err_strb   (err_strb),
    .o_pkt_cnt    (pkt_cnt),
    .o_err_cnt    (err_cnt)
  );

  initial forever #5 clk = ~clk;

  logic [72:0] fifo_q[$];
  logic [72:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int pops = 0;
  int hs = 0;
  int len_seen = 0;
  int strb_seen = 0;
  int exp_pkts = 0;
  int exp_err = 0;
  int exp_len = 0;
  int exp_strb = 0;
  int base_pops = 0;
  int base_hs = 0;
  bit chk_ahead = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // FWFT FIFO model: head consumed on the edge where the pop strobe is high
  always @(posedge clk) begin
    if (fifo_rd && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    fifo_empty <= (fifo_q.size() == 0);
    fifo_rdata <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // TX monitor: every valid beat must match the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (tx.tvalid) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 128'(exp_q.size()), 128'd1);
        end else begin
          chk("beat", 128'({tx.tlast, tx.tkeep, tx.tdata}), 128'(exp_q[0]));
          if (tx.tready) begin
            void'(exp_q.pop_front());
            hs++;
          end
        end
      end
      if (err_len) len_seen++;
      if (err_strb) strb_seen++;
      if (chk_ahead) chk("pop_ahead", 128'(((pops - base_pops) - (hs - base_hs)) <= 2), 128'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue one packet in the FIFO and the beats the framer should emit for it
  task automatic add_pkt(input int n, input logic [63:0] base, input int bad_idx);
    logic       last;
    logic [7:0] strb;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      strb = (i == bad_idx) ? 8'h0F : 8'hFF;
      fifo_q.push_back({last, strb, base + 64'(i)});
      if (i < MAXB) begin
        exp_q.push_back({last || (i == MAXB - 1), strb, base + 64'(i)});
        if (!last && strb != 8'hFF) begin
          exp_err++;
          exp_strb++;
        end
        if (!last && i == MAXB - 1) begin
          exp_err++;
          exp_len++;
        end
      end
    end
    exp_pkts++;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || !fifo_empty || busy) && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_timeout"}, 128'(k < budget), 128'd1);
    chk({tag, "_pkt_cnt"}, 128'(pkt_cnt), 128'(exp_pkts));
    chk({tag, "_err_cnt"}, 128'(err_cnt), 128'(exp_err));
    chk({tag, "_len_pulses"}, 128'(len_seen), 128'(exp_len));
    chk({tag, "_strb_pulses"}, 128'(strb_seen), 128'(exp_strb));
    chk({tag, "_busy"}, 128'(busy), 128'd0);
  endtask

  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int k;
    int b;
    tx.tready = 1'b1;
    rst = 1'b1;
    ena = 1'b1;
    // A word is available during reset but must not be popped
    add_pkt(1, 64'h100, -1);
    repeat (3) step();
    chk("rst_tvalid", 128'(tx.tvalid), 128'd0);
    chk("rst_tlast", 128'(tx.tlast), 128'd0);
    chk("rst_tdata", 128'(tx.tdata), 128'd0);
    chk("rst_tkeep", 128'(tx.tkeep), 128'd0);
    chk("rst_fifo_rd", 128'(fifo_rd), 128'd0);
    chk("rst_err_len", 128'(err_len), 128'd0);
    chk("rst_err_strb", 128'(err_strb), 128'd0);
    chk("rst_pkt_cnt", 128'(pkt_cnt), 128'd0);
    chk("rst_err_cnt", 128'(err_cnt), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_fifo_kept", 128'(fifo_q.size()), 128'd1);
    rst = 1'b0;
    drain("single", 50);

    // 4-beat packet at full rate
    add_pkt(4, 64'h1, -1);
    drain("pkt4", 50);

    // 8-beat packet with back-pressure pattern 1,0,0,1
    base_pops = pops;
    base_hs   = hs;
    chk_ahead = 1'b1;
    add_pkt(8, 64'h10, -1);
    k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < 200) begin
      tx.tready = pat[k % 4];
      step();
      k++;
    end
    chk("stall_timeout", 128'(k < 200), 128'd1);
    chk_ahead = 1'b0;
    tx.tready = 1'b1;
    drain("stall", 50);

    // Over-length packets, then an exactly max-length packet
    add_pkt(10, 64'h20, -1);
    add_pkt(3, 64'h30, -1);
    add_pkt(9, 64'h40, -1);
    add_pkt(8, 64'h50, -1);
    drain("len", 200);

    // Bad strobe on beat 2 of 3
    add_pkt(3, 64'h60, 1);
    drain("strb", 50);

    // Enable drops mid-packet with a second packet queued
    b = pops;
    add_pkt(5, 64'h70, -1);
    add_pkt(5, 64'h80, -1);
    k = 0;
    while (pops < b + 2 && k < 50) begin
      step();
      k++;
    end
    chk("ena_wait_timeout", 128'(k < 50), 128'd1);
    ena = 1'b0;
    repeat (20) step();
    chk("ena_fifo_held", 128'(fifo_q.size()), 128'd5);
    chk("ena_exp_pending", 128'(exp_q.size()), 128'd5);
    chk("ena_busy", 128'(busy), 128'd0);
    chk("ena_pkt_cnt", 128'(pkt_cnt), 128'(exp_pkts - 1));
    ena = 1'b1;
    drain("ena", 100);

    // Reset mid-packet while stalled
    tx.tready = 1'b0;
    b = pops;
    add_pkt(6, 64'h90, -1);
    k = 0;
    while (pops < b + 2 && k < 50) begin
      step();
      k++;
    end
    chk("rst2_wait_timeout", 128'(k < 50), 128'd1);
    repeat (2) step();
    #1 rst = 1'b1;
    #1;
    chk("rst2_tvalid", 128'(tx.tvalid), 128'd0);
    chk("rst2_pkt_cnt", 128'(pkt_cnt), 128'd0);
    chk("rst2_err_cnt", 128'(err_cnt), 128'd0);
    chk("rst2_busy", 128'(busy), 128'd0);
    chk("rst2_fifo_left", 128'(fifo_q.size()), 128'd4);
    // Remaining FIFO words come out as a fresh packet
    exp_q.delete();
    foreach (fifo_q[i]) exp_q.push_back(fifo_q[i]);
    exp_pkts  = 1;
    exp_err   = 0;
    exp_len   = 0;
    exp_strb  = 0;
    len_seen  = 0;
    strb_seen = 0;
    step();
    rst = 1'b0;
    tx.tready = 1'b1;
    drain("rst2", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
